// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports and mem_control ports of the memory arbiter.
// slave = arbiter side, master = core/memory side driving the requests.
interface mem_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_err_o;

    logic        d_req_i;
    logic        d_we_i;
    logic [1:0]  d_acc_i;
    logic        d_sext_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        d_err_o;

    logic        mem_sext_o;
    logic [1:0]  mem_acc_r_o;
    logic [31:0] mem_addr_r_o;
    logic [31:0] mem_data_r_i;
    logic        mem_wr_en_o;
    logic [1:0]  mem_acc_w_o;
    logic [31:0] mem_addr_w_o;
    logic [31:0] mem_data_w_o;
    logic        mem_wr_ready_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  d_req_i, d_we_i, d_acc_i, d_sext_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output mem_sext_o, mem_acc_r_o, mem_addr_r_o,
        input  mem_data_r_i,
        output mem_wr_en_o, mem_acc_w_o, mem_addr_w_o, mem_data_w_o,
        input  mem_wr_ready_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output d_req_i, d_we_i, d_acc_i, d_sext_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  mem_sext_o, mem_acc_r_o, mem_addr_r_o,
        output mem_data_r_i,
        input  mem_wr_en_o, mem_acc_w_o, mem_addr_w_o, mem_data_w_o,
        output mem_wr_ready_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one mem_control between fetch and load/store ports; checks
// alignment, sequences the two-cycle store and registers responses.
module mem_arbiter #(
    parameter bit DATA_PRIO = 1'b0
) (
    input logic       clk_i,
    input logic       rstn_i,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] MEM_ACCESS_BYTE     = 2'b00;
    localparam logic [1:0] MEM_ACCESS_HALFWORD = 2'b01;
    localparam logic [1:0] MEM_ACCESS_WORD     = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1
    } state_t;

    state_t      state, state_nxt;
    logic        last_d;
    logic [31:0] w_addr, w_data;
    logic [1:0]  w_acc;

    logic        can_gnt, pick_d;
    logic        if_gnt, d_gnt;
    logic        if_mis, d_mis;
    logic        if_rd, d_rd, d_wr;

    logic        if_rvalid, if_err, d_rvalid, d_err;
    logic [31:0] if_rdata, d_rdata;

    // last_d set means the data port won last, so fetch wins the next tie
    always_comb begin
        can_gnt = (state == ST_IDLE) && bus.mem_wr_ready_i;
        pick_d  = DATA_PRIO ? 1'b1 : !last_d;
        if_gnt  = can_gnt && bus.if_req_i && !(bus.d_req_i && pick_d);
        d_gnt   = can_gnt && bus.d_req_i && (!bus.if_req_i || pick_d);
    end

    always_comb begin
        if_mis = |bus.if_addr_i[1:0];
        unique case (bus.d_acc_i)
            MEM_ACCESS_BYTE:     d_mis = 1'b0;
            MEM_ACCESS_HALFWORD: d_mis = bus.d_addr_i[0];
            default:             d_mis = |bus.d_addr_i[1:0];
        endcase
        if_rd = if_gnt && !if_mis;
        d_rd  = d_gnt && !d_mis && !bus.d_we_i;
        d_wr  = d_gnt && !d_mis && bus.d_we_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        bus.mem_sext_o   = 1'b0;
        bus.mem_acc_r_o  = 2'b00;
        bus.mem_addr_r_o = 32'h0;
        bus.mem_wr_en_o  = 1'b0;
        bus.mem_acc_w_o  = 2'b00;
        bus.mem_addr_w_o = 32'h0;
        bus.mem_data_w_o = 32'h0;
        unique case (state)
            ST_IDLE: begin
                if (if_rd) begin
                    bus.mem_addr_r_o = bus.if_addr_i;
                    bus.mem_acc_r_o  = MEM_ACCESS_WORD;
                end
                if (d_rd) begin
                    bus.mem_addr_r_o = bus.d_addr_i;
                    bus.mem_acc_r_o  = bus.d_acc_i;
                    bus.mem_sext_o   = bus.d_sext_i;
                end
                if (d_wr) begin
                    bus.mem_wr_en_o  = 1'b1;
                    bus.mem_addr_w_o = bus.d_addr_i;
                    bus.mem_acc_w_o  = bus.d_acc_i;
                    bus.mem_data_w_o = bus.d_wdata_i;
                    state_nxt        = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // mem_control commits this cycle from the held operands
                bus.mem_addr_w_o = w_addr;
                bus.mem_acc_w_o  = w_acc;
                bus.mem_data_w_o = w_data;
                state_nxt        = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            w_addr <= 32'h0;
            w_acc  <= 2'b00;
            w_data <= 32'h0;
        end else if (d_wr) begin
            w_addr <= bus.d_addr_i;
            w_acc  <= bus.d_acc_i;
            w_data <= bus.d_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_d <= 1'b1;
        end else if (if_gnt) begin
            last_d <= 1'b0;
        end else if (d_gnt) begin
            last_d <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= 32'h0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= 32'h0;
        end else begin
            if_rvalid <= if_gnt;
            if_err    <= if_gnt && if_mis;
            if_rdata  <= if_rd ? bus.mem_data_r_i : 32'h0;
            d_rvalid  <= d_gnt;
            d_err     <= d_gnt && d_mis;
            d_rdata   <= d_rd ? bus.mem_data_r_i : 32'h0;
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.if_rvalid_o = if_rvalid;
    assign bus.if_err_o    = if_err;
    assign bus.if_rdata_o  = if_rdata;
    assign bus.d_gnt_o     = d_gnt;
    assign bus.d_rvalid_o  = d_rvalid;
    assign bus.d_err_o     = d_err;
    assign bus.d_rdata_o   = d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, hand sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;
    localparam logic [1:0] AB = 2'b00;
    localparam logic [1:0] AH = 2'b01;
    localparam logic [1:0] AW = 2'b10;

    typedef struct {
        logic        we;
        logic [1:0]  acc;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic mem_clr = 1'b1;
    logic ready;
    logic wr_pend;
    logic [7:0] mem [1024];
    logic [7:0] ref_mem [1024];
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter_if b0 ();
    mem_arbiter_if b1 ();

    mem_arbiter #(.DATA_PRIO(1'b0)) dut0 (.clk_i(clk), .rstn_i(rstn), .bus(b0));
    mem_arbiter #(.DATA_PRIO(1'b1)) dut1 (.clk_i(clk), .rstn_i(rstn), .bus(b1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ready <= 1'b0;
        else ready <= 1'b1;
    end
    assign b0.mem_wr_ready_i = ready;
    assign b1.mem_wr_ready_i = ready;

    function automatic logic [31:0] dec(logic [7:0] x0, logic [7:0] x1,
                                        logic [7:0] x2, logic [7:0] x3,
                                        logic [1:0] acc, logic sx);
        case (acc)
            AB: return sx ? {{24{x0[7]}}, x0} : {24'h0, x0};
            AH: return sx ? {{16{x1[7]}}, x1, x0} : {16'h0, x1, x0};
            default: return {x3, x2, x1, x0};
        endcase
    endfunction

    // mem_control stand-in: combinational read, commit one cycle after wr_en
    logic [9:0] ra0, ra1, wa;
    assign ra0 = b0.mem_addr_r_o[9:0];
    assign ra1 = b1.mem_addr_r_o[9:0];
    assign wa  = b0.mem_addr_w_o[9:0];
    always_comb b0.mem_data_r_i = dec(mem[ra0], mem[ra0 + 10'd1], mem[ra0 + 10'd2],
                                      mem[ra0 + 10'd3], b0.mem_acc_r_o, b0.mem_sext_o);
    always_comb b1.mem_data_r_i = dec(mem[ra1], mem[ra1 + 10'd1], mem[ra1 + 10'd2],
                                      mem[ra1 + 10'd3], b1.mem_acc_r_o, b1.mem_sext_o);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) wr_pend <= 1'b0;
        else wr_pend <= b0.mem_wr_en_o;
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (wr_pend) begin
            mem[wa] <= b0.mem_data_w_o[7:0];
            if (b0.mem_acc_w_o != AB) mem[wa + 10'd1] <= b0.mem_data_w_o[15:8];
            if (b0.mem_acc_w_o == AW) begin
                mem[wa + 10'd2] <= b0.mem_data_w_o[23:16];
                mem[wa + 10'd3] <= b0.mem_data_w_o[31:24];
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    function automatic bit misal(logic [31:0] a, logic [1:0] acc);
        if (acc == AB) return 1'b0;
        if (acc == AH) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a, logic [1:0] acc, logic sx);
        logic [9:0] i;
        i = a[9:0];
        return dec(ref_mem[i], ref_mem[i + 10'd1], ref_mem[i + 10'd2],
                   ref_mem[i + 10'd3], acc, sx);
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [1:0] acc, input logic [31:0] d);
        int n;
        n = (acc == AB) ? 1 : (acc == AH) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[(a + k) % 1024] = d[8*k +: 8];
    endtask

    task automatic d_txn(input vec_t v, input int idx);
        logic st;
        st = v.we && !v.err;
        b0.d_req_i   = 1'b1;
        b0.d_we_i    = v.we;
        b0.d_acc_i   = v.acc;
        b0.d_sext_i  = v.sx;
        b0.d_addr_i  = v.addr;
        b0.d_wdata_i = v.wdata;
        #1;
        chk($sformatf("v%0d d_gnt", idx), b0.d_gnt_o, 1);
        chk($sformatf("v%0d wr_en_T", idx), b0.mem_wr_en_o, st);
        @(negedge clk);
        b0.d_req_i = 1'b0;
        if (st) begin
            b0.if_req_i  = 1'b1;
            b0.if_addr_i = 32'h40;
        end
        #1;
        chk($sformatf("v%0d rvalid", idx), b0.d_rvalid_o, 1);
        chk($sformatf("v%0d err", idx), b0.d_err_o, v.err);
        chk($sformatf("v%0d rdata", idx), b0.d_rdata_o, v.rdata);
        if (st) begin
            chk($sformatf("v%0d wr_en_T1", idx), b0.mem_wr_en_o, 0);
            chk($sformatf("v%0d addr_w", idx), b0.mem_addr_w_o, v.addr);
            chk($sformatf("v%0d data_w", idx), b0.mem_data_w_o, v.wdata);
            chk($sformatf("v%0d acc_w", idx), b0.mem_acc_w_o, v.acc);
            chk($sformatf("v%0d if_gnt_T1", idx), b0.if_gnt_o, 0);
        end
        @(negedge clk);
        b0.if_req_i = 1'b0;
        #1;
        chk($sformatf("v%0d rvalid_pulse", idx), b0.d_rvalid_o, 0);
    endtask

    vec_t tv [10];

    logic        ip, dp, dwe, dsx, lastd, busy;
    logic        eg_i, eg_d;
    logic [1:0]  dacc;
    logic [31:0] ia, da, dwd;
    logic        e_iv, e_ie, e_dv, e_de;
    logic [31:0] e_id, e_dd;

    function automatic logic [31:0] rnd_addr(logic [1:0] acc);
        int a;
        a = $urandom_range(1023, 0);
        if ($urandom_range(3, 0) != 0) begin
            if (acc == AH) a = a & ~1;
            if (acc == AW) a = a & ~3;
        end
        return 32'(a);
    endfunction

    initial begin
        tv[0] = '{1'b1, AW, 1'b0, 32'h100, 32'h80FF1234, 32'h0, 1'b0};
        tv[1] = '{1'b0, AB, 1'b1, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0};
        tv[2] = '{1'b0, AH, 1'b0, 32'h102, 32'h0, 32'h000080FF, 1'b0};
        tv[3] = '{1'b1, AB, 1'b0, 32'h101, 32'h000000AB, 32'h0, 1'b0};
        tv[4] = '{1'b0, AW, 1'b0, 32'h100, 32'h0, 32'h80FFAB34, 1'b0};
        tv[5] = '{1'b0, AH, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1};
        tv[6] = '{1'b1, AW, 1'b0, 32'h102, 32'hDEADBEEF, 32'h0, 1'b1};
        tv[7] = '{1'b0, AW, 1'b0, 32'h100, 32'h0, 32'h80FFAB34, 1'b0};
        tv[8] = '{1'b0, AH, 1'b1, 32'h102, 32'h0, 32'hFFFF80FF, 1'b0};
        tv[9] = '{1'b0, AB, 1'b0, 32'h101, 32'h0, 32'h000000AB, 1'b0};

        b0.if_req_i = 0; b0.if_addr_i = 0; b0.d_req_i = 0; b0.d_we_i = 0;
        b0.d_acc_i = AW; b0.d_sext_i = 0; b0.d_addr_i = 0; b0.d_wdata_i = 0;
        b1.if_req_i = 0; b1.if_addr_i = 0; b1.d_req_i = 0; b1.d_we_i = 0;
        b1.d_acc_i = AW; b1.d_sext_i = 0; b1.d_addr_i = 0; b1.d_wdata_i = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst if_rvalid", b0.if_rvalid_o, 0);
        chk("rst d_rvalid", b0.d_rvalid_o, 0);
        chk("rst if_err", b0.if_err_o, 0);
        chk("rst d_err", b0.d_err_o, 0);
        chk("rst if_rdata", b0.if_rdata_o, 0);
        chk("rst d_rdata", b0.d_rdata_o, 0);
        chk("rst wr_en", b0.mem_wr_en_o, 0);
        chk("rst addr_w", b0.mem_addr_w_o, 0);
        chk("rst addr_r", b0.mem_addr_r_o, 0);
        chk("rst gnts", {b0.if_gnt_o, b0.d_gnt_o}, 0);

        @(negedge clk);
        mem_clr = 1'b0;
        rstn = 1'b1;
        b0.if_req_i = 1; b0.if_addr_i = 32'h100; b0.d_req_i = 1; b0.d_addr_i = 32'h100;
        b1.if_req_i = 1; b1.if_addr_i = 32'h100; b1.d_req_i = 1; b1.d_addr_i = 32'h100;
        #1;
        chk("post-rst gnt0", {b0.if_gnt_o, b0.d_gnt_o}, 0);
        chk("post-rst gnt1", {b1.if_gnt_o, b1.d_gnt_o}, 0);

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d if_gnt", k), b0.if_gnt_o, (k % 2) == 0);
            chk($sformatf("rr%0d d_gnt", k), b0.d_gnt_o, (k % 2) == 1);
            chk($sformatf("prio%0d d_gnt", k), b1.d_gnt_o, 1);
            chk($sformatf("prio%0d if_gnt", k), b1.if_gnt_o, 0);
            if (k > 0) chk($sformatf("rr%0d if_rvalid", k), b0.if_rvalid_o, (k % 2) == 1);
        end
        @(negedge clk);
        b0.if_req_i = 0; b0.d_req_i = 0; b1.if_req_i = 0; b1.d_req_i = 0;
        #1;
        chk("rr d_rvalid", b0.d_rvalid_o, 1);
        chk("prio if_rvalid", b1.if_rvalid_o, 0);
        chk("prio d_rvalid", b1.d_rvalid_o, 1);

        @(negedge clk);
        for (int i = 0; i < 10; i++) d_txn(tv[i], i);

        b0.if_req_i = 1; b0.if_addr_i = 32'h006;
        #1;
        chk("ifmis gnt", b0.if_gnt_o, 1);
        chk("ifmis addr_r", b0.mem_addr_r_o, 0);
        @(negedge clk);
        b0.if_addr_i = 32'h100;
        #1;
        chk("ifmis rvalid", b0.if_rvalid_o, 1);
        chk("ifmis err", b0.if_err_o, 1);
        chk("ifmis rdata", b0.if_rdata_o, 0);
        chk("if gnt", b0.if_gnt_o, 1);
        @(negedge clk);
        b0.if_req_i = 0;
        #1;
        chk("if rdata", b0.if_rdata_o, 32'h80FFAB34);
        chk("if err", b0.if_err_o, 0);

        @(negedge clk);
        b0.d_req_i = 1; b0.d_we_i = 1; b0.d_acc_i = AW;
        b0.d_addr_i = 32'h200; b0.d_wdata_i = 32'h11223344;
        #1;
        chk("rstw gnt", b0.d_gnt_o, 1);
        @(negedge clk);
        b0.d_req_i = 0;
        #1;
        rstn = 1'b0;
        #1;
        chk("rstw d_rvalid", b0.d_rvalid_o, 0);
        chk("rstw addr_w", b0.mem_addr_w_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        d_txn('{1'b0, AW, 1'b0, 32'h200, 32'h0, 32'h0, 1'b0}, 10);

        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        ip = 0; dp = 0; lastd = 1; busy = 0;
        e_iv = 0; e_ie = 0; e_id = 0; e_dv = 0; e_de = 0; e_dd = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd if_rvalid", b0.if_rvalid_o, e_iv);
            chk("rnd if_err", b0.if_err_o, e_ie);
            chk("rnd if_rdata", b0.if_rdata_o, e_id);
            chk("rnd d_rvalid", b0.d_rvalid_o, e_dv);
            chk("rnd d_err", b0.d_err_o, e_de);
            chk("rnd d_rdata", b0.d_rdata_o, e_dd);
            if (!ip && $urandom_range(1, 0) == 1) begin
                ip = 1;
                ia = rnd_addr(AW);
            end
            if (!dp && $urandom_range(1, 0) == 1) begin
                dp = 1;
                dwe = 1'($urandom_range(1, 0));
                dacc = 2'($urandom_range(2, 0));
                dsx = 1'($urandom_range(1, 0));
                da = rnd_addr(dacc);
                dwd = $urandom;
                if (dacc == AB) dwd = dwd & 32'hFF;
                if (dacc == AH) dwd = dwd & 32'hFFFF;
            end
            b0.if_req_i = ip; b0.if_addr_i = ia;
            b0.d_req_i = dp; b0.d_we_i = dwe; b0.d_acc_i = dacc;
            b0.d_sext_i = dsx; b0.d_addr_i = da; b0.d_wdata_i = dwd;
            #1;
            eg_i = !busy && ip && (!dp || lastd);
            eg_d = !busy && dp && (!ip || !lastd);
            chk("rnd if_gnt", b0.if_gnt_o, eg_i);
            chk("rnd d_gnt", b0.d_gnt_o, eg_d);
            busy = 0;
            e_iv = eg_i;
            e_ie = eg_i && misal(ia, AW);
            e_id = (eg_i && !e_ie) ? ref_rd(ia, AW, 1'b0) : 32'h0;
            e_dv = eg_d;
            e_de = eg_d && misal(da, dacc);
            e_dd = (eg_d && !e_de && !dwe) ? ref_rd(da, dacc, dsx) : 32'h0;
            if (eg_i) begin
                lastd = 0;
                ip = 0;
            end
            if (eg_d) begin
                lastd = 1;
                dp = 0;
                if (dwe && !e_de) begin
                    ref_wr(da, dacc, dwd);
                    busy = 1;
                end
            end
        end
        @(negedge clk);
        chk("rnd last if_rvalid", b0.if_rvalid_o, e_iv);
        chk("rnd last d_rvalid", b0.d_rvalid_o, e_dv);
        chk("rnd last d_rdata", b0.d_rdata_o, e_dd);
        b0.if_req_i = 0; b0.d_req_i = 0;

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single mem_control instance between the instruction-fetch port and the load/store data port.
- Arbitrates requests, checks alignment and sequences the two-cycle read-modify-write store that mem_control needs, holding write operands stable across both cycles.
- Returns registered responses with fixed one-cycle latency.
- Sits between the core pipeline and mem_control.

Parameters:
- DATA_PRIO, 0: 0 = round-robin between fetch and data; 1 = data port has fixed priority.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; address stable until granted
- if_addr_i  in  32  fetch address (word access, no sign extension)
- if_gnt_o  out  1  fetch granted this cycle (combinational)
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  32  fetch data
- if_err_o  out  1  fetch misaligned, qualified by if_rvalid_o
- d_req_i  in  1  data request; all d_* inputs stable until granted
- d_we_i  in  1  1 = store, 0 = load
- d_acc_i  in  2  access size, MEM_ACCESS_BYTE / HALFWORD / WORD
- d_sext_i  in  1  sign-extend load
- d_addr_i  in  32  data address
- d_wdata_i  in  32  store data, right-aligned
- d_gnt_o  out  1  data granted this cycle (combinational)
- d_rvalid_o  out  1  load data valid or store acknowledged
- d_rdata_o  out  32  load data; 0 for stores
- d_err_o  out  1  data misaligned, qualified by d_rvalid_o
- mem_sext_o, mem_acc_r_o[2], mem_addr_r_o[32]  out  mem_control read port
- mem_data_r_i  in  32  mem_control read data (combinational)
- mem_wr_en_o, mem_acc_w_o[2], mem_addr_w_o[32], mem_data_w_o[32]  out  mem_control write port
- mem_wr_ready_i  in  1  mem_control ready

Behaviour:
- States: ST_IDLE, ST_WRITE. Reset gives ST_IDLE.
- Reset values: rvalid, err and rdata outputs = 0; last_gnt = data (fetch wins first tie).
- All mem_* outputs are 0 when not driven by a grant or by ST_WRITE.
- Grant condition: a grant happens only in ST_IDLE with mem_wr_ready_i = 1. No grant during mem_control's post-reset cycle.
- At most one grant per cycle.
- Arbitration when both ports request:
  - DATA_PRIO = 1: data wins.
  - DATA_PRIO = 0: the port not in last_gnt wins.
  - last_gnt updates on every grant.
- Misalignment, checked before any memory access:
  - Fetch: addr[1:0] != 0.
  - Halfword: addr[0] = 1.
  - Word: addr[1:0] != 0.
  - Byte: never misaligned.
  - A misaligned request is still granted and consumes the arbitration slot.
  - No mem_* activity for it (mem_wr_en_o = 0).
  - Response at T+1: rvalid = 1, err = 1, rdata = 0.
- Read granted at cycle T (fetch, or data with d_we_i = 0):
  - Drive mem_addr_r_o = addr, mem_acc_r_o, mem_sext_o (fetch: WORD, sext 0) in T.
  - Register mem_data_r_i at the end of T.
  - rvalid = 1 with rdata at T+1; err = 0.
  - Back-to-back reads every cycle are supported.
- Store granted at cycle T:
  - In T: drive mem_wr_en_o = 1, mem_addr_w_o = d_addr_i, mem_acc_w_o, mem_data_w_o.
  - Latch addr, acc and data; go to ST_WRITE.
  - T+1 (ST_WRITE): mem_wr_en_o = 0; mem_addr_w_o, mem_acc_w_o, mem_data_w_o driven from the latches (mem_control commits at end of T+1).
  - d_rvalid_o = 1 and d_rdata_o = 0 at T+1; no grants in T+1.
  - Return to ST_IDLE at T+2.
  - A read granted at T+2 observes the stored value.
- Response pulses: rvalid is a single-cycle pulse, independent of further requests. Ungranted requests wait indefinitely with gnt_o = 0.
- Invalid state: recover to ST_IDLE.
- Reset mid-operation: state returns to ST_IDLE, an in-flight store is dropped, and pending rvalid is cleared immediately (asynchronous).

Test Plan:
- Reset, both ports idle → all outputs 0. The cycle after reset release (mem_wr_ready_i = 0) gives no grant even with if_req_i = 1.
- Memory word 0x100 = 0x80FF1234. Data byte load, sext = 1, addr 0x103 → d_rvalid_o at T+1, d_rdata_o = 0xFFFFFF80. Unsigned halfword at 0x102 → 0x000080FF.
- Store byte 0xAB to 0x101 at T → mem_wr_en_o = 1 only in T, operands held in T+1, d_rvalid_o at T+1, no grant at T+1. Word load at T+2 → 0x80FFAB34.
- DATA_PRIO = 0, both ports requesting continuously → grants alternate fetch, data, fetch, data. DATA_PRIO = 1 → data granted every cycle and fetch starved.
- Halfword load at 0x101, word store at 0x102, fetch at 0x006 → each granted, err = 1 with rvalid at T+1, rdata = 0, mem_wr_en_o never asserted, memory unchanged.
- rstn_i asserted during ST_WRITE → state ST_IDLE, d_rvalid_o = 0 immediately; after release, normal grants resume.
